// File: rtl/layer_vec_pingpong.sv
// Two-bank ping-pong buffer between layers: collects one VLEN-word vector per bank
// (optional ReLU on write) and replays the banks word by word in arrival order.
module layer_vec_pingpong #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned VLEN  = 3,
   parameter int unsigned LOGV  = 2,
   parameter int unsigned RELU  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic signed [WIDTH-1:0] data_in,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic signed [WIDTH-1:0] data_out,
   output logic [1:0]              full_cnt
);

   localparam logic [LOGV-1:0] LAST_IDX = LOGV'(VLEN - 1);

   logic [1:0]              full_q,    full_d;
   logic                    wr_bank_q, wr_bank_d;
   logic                    rd_bank_q, rd_bank_d;
   logic [LOGV-1:0]         wr_cnt_q,  wr_cnt_d;
   logic [LOGV-1:0]         rd_cnt_q,  rd_cnt_d;
   logic signed [WIDTH-1:0] mem [2][VLEN];
   logic                    wr_fire;
   logic                    rd_fire;
   logic signed [WIDTH-1:0] wr_word;

   // Handshakes and read mux; the producer only ever sees the bank it is filling
   always_comb begin
      s_ready  = !full_q[wr_bank_q] && !reset;
      m_valid  = full_q[rd_bank_q];
      wr_fire  = s_valid && s_ready;
      rd_fire  = m_valid && m_ready;
      data_out = mem[rd_bank_q][rd_cnt_q];
      wr_word  = ((RELU != 0) && data_in[WIDTH-1]) ? '0 : data_in;
      full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   end

   // Next-state: read and write always touch different banks, so both may complete together
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;

      if (rd_fire) begin
         if (rd_cnt_q == LAST_IDX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + LOGV'(1);
         end
      end

      if (wr_fire) begin
         if (wr_cnt_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + LOGV'(1);
         end
      end
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (reset) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   // Vector storage is left uncleared; full flags alone decide what is valid
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_bank_q][wr_cnt_q] <= wr_word;
      end
   end

endmodule

// File: tb/tb_layer_vec_pingpong.sv
// Bench for layer_vec_pingpong: queue-based vector model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_layer_vec_pingpong;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned VLEN  = 3;
   localparam int unsigned LOGV  = 2;
   localparam int unsigned RELU  = 1;

   logic                    clk     = 1'b0;
   logic                    reset   = 1'b1;
   logic                    s_valid = 1'b0;
   logic                    m_ready = 1'b0;
   logic signed [WIDTH-1:0] data_in = '0;
   logic                    s_ready;
   logic                    m_valid;
   logic signed [WIDTH-1:0] data_out;
   logic [1:0]              full_cnt;

   always #5 clk = ~clk;

   layer_vec_pingpong #(.WIDTH(WIDTH), .VLEN(VLEN), .LOGV(LOGV), .RELU(RELU)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
      .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
      .full_cnt(full_cnt)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: words of the vector being collected, and words of complete vectors awaiting readout
   int part_q[$];
   int out_q[$];
   int nfull  = 0;
   int rd_pos = 0;
   bit armed  = 1'b0;
   bit m_wr, m_rd;

   int log_q[$];
   int lcyc_q[$];

   function automatic int relu_f(int v);
      return (RELU != 0 && v < 0) ? 0 : v;
   endfunction

   task automatic check(string name, longint act, longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model update on each rising edge, from the inputs held across that edge
   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
         part_q.delete();
         out_q.delete();
         nfull  = 0;
         rd_pos = 0;
         armed  = 1'b1;
      end else if (armed) begin
         m_wr = s_valid && (nfull < 2);
         m_rd = (nfull > 0) && m_ready;
         if (m_rd) begin
            void'(out_q.pop_front());
            rd_pos++;
            if (rd_pos == int'(VLEN)) begin
               rd_pos = 0;
               nfull--;
            end
         end
         if (m_wr) begin
            part_q.push_back(relu_f(int'(data_in)));
            if (part_q.size() == int'(VLEN)) begin
               foreach (part_q[i]) out_q.push_back(part_q[i]);
               part_q.delete();
               nfull++;
            end
         end
      end
   end

   // Compare on every falling edge and log the words the consumer takes
   initial forever begin
      @(negedge clk);
      if (armed) begin
         check("s_ready", s_ready, !reset && nfull < 2);
         check("m_valid", m_valid, nfull > 0);
         check("full_cnt", full_cnt, nfull);
         if (nfull > 0) check("data_out", data_out, out_q[0]);
         if (m_valid && m_ready && !reset) begin
            log_q.push_back(int'(data_out));
            lcyc_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic send(int d);
      logic acc;
      int   tries;
      tries   = 0;
      s_valid = 1'b1;
      data_in = WIDTH'(d);
      forever begin
         @(negedge clk);
         acc = s_ready;
         tick();
         if (acc) break;
         tries++;
         if (tries > 200) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic drain(int n);
      m_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (log_q.size() >= n) break;
         tick();
      end
      check("drain_count", log_q.size(), n);
   endtask

   task automatic check_log(string name, input int exp[$]);
      check({name, "_len"}, log_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         check(name, log_q[i], exp[i]);
   endtask

   task automatic clear_log();
      log_q.delete();
      lcyc_q.delete();
   endtask

   initial begin
      int e[$];
      int ls;
      logic acc;
      int n;

      // Reset with s_valid held high
      s_valid = 1'b1;
      data_in = 16'sd5;
      repeat (3) tick();
      sample();
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_full_cnt", full_cnt, 0);
      @(posedge clk); #1;
      reset   = 1'b0;
      s_valid = 1'b0;
      sample();
      check("rst_release_s_ready", s_ready, 1);
      tick();

      // ReLU on write
      clear_log();
      m_ready = 1'b1;
      send(-40); send(105); send(-1);
      sample();
      check("relu_mvalid_latency", m_valid, 1);
      check("relu_first_word", data_out, 0);
      drain(3);
      e = '{0, 105, 0};
      check_log("relu_log", e);

      // Backpressure holds word 0, then three words on consecutive cycles
      clear_log();
      m_ready = 1'b0;
      send(11); send(-22); send(33);
      repeat (5) tick();
      sample();
      check("bp_hold_valid", m_valid, 1);
      check("bp_hold_data", data_out, 11);
      check("bp_full_cnt", full_cnt, 1);
      tick();
      drain(3);
      e = '{11, 0, 33};
      check_log("bp_log", e);
      if (lcyc_q.size() == 3) check("bp_consecutive", lcyc_q[2] - lcyc_q[0], 2);

      // Ping-pong: both banks full stalls the producer until bank A drains
      clear_log();
      m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send(i);
      sample();
      check("pp_full_cnt", full_cnt, 2);
      check("pp_s_ready", s_ready, 0);
      s_valid = 1'b1;
      data_in = 16'sd7;
      repeat (3) begin
         tick();
         sample();
         check("pp_stall", s_ready, 0);
      end
      tick();
      m_ready = 1'b1;
      n  = 0;
      ls = -1;
      do begin
         sample();
         acc = s_ready;
         if (acc) ls = log_q.size();
         tick();
         n++;
      end while (!acc && n < 20);
      // ready returns while word 4 (head of bank B) is being presented
      check("pp_ready_after_drain", ls, 4);
      s_valid = 1'b0;
      send(8); send(9);
      drain(9);
      e = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      check_log("pp_log", e);

      // Streaming: no gaps once the first vector is out
      clear_log();
      m_ready = 1'b1;
      e.delete();
      for (int i = 0; i < 12; i++) begin
         send(100 + i * 7);
         e.push_back(100 + i * 7);
      end
      drain(12);
      check_log("stream_log", e);
      if (lcyc_q.size() == 12) check("stream_no_gaps", lcyc_q[11] - lcyc_q[0], 11);

      // Reset mid-vector discards the partial vector
      clear_log();
      m_ready = 1'b1;
      send(50); send(60);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      send(7); send(8); send(9);
      drain(3);
      repeat (5) tick();
      e = '{7, 8, 9};
      check_log("midrst_log", e);

      // Randomized traffic with phases of heavy backpressure and rare resets
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 500; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            data_in = WIDTH'($urandom);
            m_ready = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 399) == 0);
            tick();
         end
      end
      reset   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
